// File: rtl/ad7799_scan.sv
// ad7799_scan: channel-scan sequencer in front of the ad7799 SPI driver.
// On start it resets the ADC once, waits RST_WAIT cycles, then for each
// enabled channel writes the configuration register, runs one conversion and
// emits the 24-bit result on a one-cycle sample strobe.
//
// Ports:
//   sys_clk, reset_n          clock and asynchronous active-low reset
//   start, stop, cont         scan control (cont/ch_mask sampled at start)
//   ch_mask[2:0]              enabled channels, bit n = AIN(n+1)
//   cfg_base[15:0], rate[3:0] config template and update-rate code
//   drv_*                     request/response interface to the ad7799 driver
//   running                   high while a scan is in progress
//   sample_vld/ch/data        result strobe, channel index and data
//   scan_done                 one-cycle strobe at the end of each pass
module ad7799_scan #(
  parameter int unsigned RST_WAIT = 5000,
  parameter int unsigned CNT_W    = 16
) (
  input  logic        sys_clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic        stop,
  input  logic        cont,
  input  logic [2:0]  ch_mask,
  input  logic [15:0] cfg_base,
  input  logic [3:0]  rate,
  output logic        drv_wrreq,
  output logic        drv_reset_req,
  output logic        drv_single_conv_req,
  output logic [2:0]  drv_rs,
  output logic [23:0] drv_din,
  input  logic        drv_busy,
  input  logic        drv_ready,
  input  logic [23:0] drv_dout,
  output logic        running,
  output logic        sample_vld,
  output logic [1:0]  sample_ch,
  output logic [23:0] sample_data,
  output logic        scan_done
);

  typedef enum logic [3:0] {
    StIdle,
    StRst,
    StRstAck,
    StRstDone,
    StRwait,
    StCfg,
    StCfgAck,
    StCfgDone,
    StConv,
    StConvAck,
    StConvWait,
    StNext
  } state_e;

  state_e           state_q;
  logic [1:0]       ptr_q;
  logic [CNT_W-1:0] cnt_q;
  logic             cont_q;
  logic [2:0]       mask_q;
  logic             stop_pend_q;
  logic             cap_pend_q;  // ready seen last cycle; dout valid now
  logic             got_q;       // a ready has already been taken this conversion

  // Low config bits are replaced by the channel number.
  logic unused_cfg;
  assign unused_cfg = ^cfg_base[2:0];

  function automatic logic [1:0] first_ch(input logic [2:0] m);
    if (m[0]) begin
      return 2'd0;
    end else if (m[1]) begin
      return 2'd1;
    end else begin
      return 2'd2;
    end
  endfunction

  // Next enabled channel above p, wrapping to the lowest enabled one.
  function automatic logic [1:0] next_ch(input logic [2:0] m, input logic [1:0] p);
    logic [1:0] r;
    r = first_ch(m);
    unique case (p)
      2'd0: begin
        if (m[1]) begin
          r = 2'd1;
        end else if (m[2]) begin
          r = 2'd2;
        end
      end
      2'd1: begin
        if (m[2]) begin
          r = 2'd2;
        end
      end
      default: ;
    endcase
    return r;
  endfunction

  logic       stop_now;
  logic [1:0] nxt_ptr;
  logic       wrap;

  always_comb begin
    stop_now = stop_pend_q | stop;
    nxt_ptr  = next_ch(mask_q, ptr_q);
    // A single enabled channel maps onto itself, which also counts as a wrap.
    wrap     = (nxt_ptr <= ptr_q);
  end

  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q             <= StIdle;
      ptr_q               <= 2'd0;
      cnt_q               <= '0;
      cont_q              <= 1'b0;
      mask_q              <= 3'd0;
      stop_pend_q         <= 1'b0;
      cap_pend_q          <= 1'b0;
      got_q               <= 1'b0;
      drv_wrreq           <= 1'b0;
      drv_reset_req       <= 1'b0;
      drv_single_conv_req <= 1'b0;
      drv_rs              <= 3'd0;
      drv_din             <= 24'd0;
      running             <= 1'b0;
      sample_vld          <= 1'b0;
      sample_ch           <= 2'd0;
      sample_data         <= 24'd0;
      scan_done           <= 1'b0;
    end else begin
      drv_wrreq           <= 1'b0;
      drv_reset_req       <= 1'b0;
      drv_single_conv_req <= 1'b0;
      sample_vld          <= 1'b0;
      scan_done           <= 1'b0;

      if (state_q != StIdle && stop) begin
        stop_pend_q <= 1'b1;
      end

      // The driver updates dout on the same edge as ready, so take it a cycle later.
      if (state_q == StConvAck || state_q == StConvWait) begin
        if (drv_ready && !got_q) begin
          got_q      <= 1'b1;
          cap_pend_q <= 1'b1;
        end
        if (cap_pend_q) begin
          cap_pend_q  <= 1'b0;
          sample_vld  <= 1'b1;
          sample_ch   <= ptr_q;
          sample_data <= drv_dout;
        end
      end

      unique case (state_q)
        StIdle: begin
          stop_pend_q <= 1'b0;
          if (start) begin
            if (ch_mask != 3'd0) begin
              mask_q  <= ch_mask;
              cont_q  <= cont;
              running <= 1'b1;
              state_q <= StRst;
            end else begin
              scan_done <= 1'b1;
            end
          end
        end

        StRst: begin
          if (!drv_busy) begin
            drv_reset_req <= 1'b1;
            state_q       <= StRstAck;
          end
        end

        StRstAck: begin
          if (drv_busy) begin
            state_q <= StRstDone;
          end
        end

        StRstDone: begin
          if (!drv_busy) begin
            cnt_q   <= CNT_W'(RST_WAIT);
            state_q <= StRwait;
          end
        end

        StRwait: begin
          if (stop_now) begin
            state_q     <= StIdle;
            running     <= 1'b0;
            stop_pend_q <= 1'b0;
          end else if (cnt_q == '0) begin
            ptr_q   <= first_ch(mask_q);
            state_q <= StCfg;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end

        StCfg: begin
          if (!drv_busy) begin
            drv_wrreq <= 1'b1;
            drv_rs    <= 3'd2;
            drv_din   <= {8'h00, cfg_base[15:3], 1'b0, ptr_q};
            state_q   <= StCfgAck;
          end
        end

        StCfgAck: begin
          if (drv_busy) begin
            state_q <= StCfgDone;
          end
        end

        StCfgDone: begin
          if (!drv_busy) begin
            state_q <= StConv;
          end
        end

        StConv: begin
          if (!drv_busy) begin
            drv_single_conv_req <= 1'b1;
            drv_din             <= {20'h0, rate};
            cap_pend_q          <= 1'b0;
            got_q               <= 1'b0;
            state_q             <= StConvAck;
          end
        end

        StConvAck: begin
          if (drv_busy) begin
            state_q <= StConvWait;
          end
        end

        StConvWait: begin
          // Stay until any pending capture has been emitted.
          if (!drv_busy && !cap_pend_q && !(drv_ready && !got_q)) begin
            state_q <= StNext;
          end
        end

        StNext: begin
          if (stop_now) begin
            state_q     <= StIdle;
            running     <= 1'b0;
            stop_pend_q <= 1'b0;
          end else begin
            ptr_q <= nxt_ptr;
            if (wrap) begin
              scan_done <= 1'b1;
              if (!cont_q) begin
                state_q     <= StIdle;
                running     <= 1'b0;
                stop_pend_q <= 1'b0;
              end else begin
                state_q <= StCfg;
              end
            end else begin
              state_q <= StCfg;
            end
          end
        end

        default: begin
          state_q <= StIdle;
          running <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ad7799_scan.sv
// Testbench for ad7799_scan: behavioural ad7799 driver model (8-cycle busy,
// ready with data near the end of a conversion), a negedge monitor logging
// every request and sample, and directed scenario tasks.
module tb_ad7799_scan;

  localparam int unsigned RstWait = 20;

  logic        sys_clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        cont = 1'b0;
  logic [2:0]  ch_mask = 3'd0;
  logic [15:0] cfg_base = 16'd0;
  logic [3:0]  rate = 4'd0;
  logic        drv_wrreq, drv_reset_req, drv_single_conv_req;
  logic [2:0]  drv_rs;
  logic [23:0] drv_din;
  logic        drv_busy, drv_ready;
  logic [23:0] drv_dout;
  logic        running, sample_vld, scan_done;
  logic [1:0]  sample_ch;
  logic [23:0] sample_data;

  int checks = 0;
  int failures = 0;
  bit dbl_ready = 1'b0;

  ad7799_scan #(.RST_WAIT(RstWait), .CNT_W(16)) dut (
    .sys_clk            (sys_clk),
    .reset_n            (reset_n),
    .start              (start),
    .stop               (stop),
    .cont               (cont),
    .ch_mask            (ch_mask),
    .cfg_base           (cfg_base),
    .rate               (rate),
    .drv_wrreq          (drv_wrreq),
    .drv_reset_req      (drv_reset_req),
    .drv_single_conv_req(drv_single_conv_req),
    .drv_rs             (drv_rs),
    .drv_din            (drv_din),
    .drv_busy           (drv_busy),
    .drv_ready          (drv_ready),
    .drv_dout           (drv_dout),
    .running            (running),
    .sample_vld         (sample_vld),
    .sample_ch          (sample_ch),
    .sample_data        (sample_data),
    .scan_done          (scan_done)
  );

  always #5 sys_clk = ~sys_clk;

  function automatic logic [23:0] conv_data(input logic [2:0] ch);
    case (ch)
      3'd0:    return 24'hA5A5A5;
      3'd1:    return 24'h654321;
      3'd2:    return 24'h123456;
      default: return 24'h000000;
    endcase
  endfunction

  // Driver model
  logic [3:0] bcnt;
  logic [1:0] kind;
  logic [2:0] cur_ch;
  always @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      drv_busy  <= 1'b0;
      drv_ready <= 1'b0;
      drv_dout  <= 24'd0;
      bcnt      <= 4'd0;
      kind      <= 2'd0;
      cur_ch    <= 3'd0;
    end else begin
      drv_ready <= 1'b0;
      if (drv_busy) begin
        bcnt <= bcnt - 4'd1;
        if (kind == 2'd2 && bcnt == 4'd4) begin
          drv_ready <= 1'b1;
          drv_dout  <= conv_data(cur_ch);
        end
        if (kind == 2'd2 && dbl_ready && bcnt == 4'd2) begin
          drv_ready <= 1'b1;
          drv_dout  <= 24'hBAD000;
        end
        if (bcnt == 4'd1) drv_busy <= 1'b0;
      end else if (drv_reset_req || drv_wrreq || drv_single_conv_req) begin
        drv_busy <= 1'b1;
        bcnt     <= 4'd8;
        kind     <= drv_reset_req ? 2'd0 : (drv_wrreq ? 2'd1 : 2'd2);
        if (drv_wrreq) cur_ch <= drv_din[2:0];
      end
    end
  end

  // Monitor
  int cyc = 0;
  int n_rst = 0, n_wr = 0, n_conv = 0, n_samp = 0, n_done = 0, n_viol = 0;
  int rst_done_cyc = 0, last_gap = 0;
  bit prev_busy = 1'b0, wr_after_rst = 1'b0;
  logic [23:0] wr_din_log [0:63];
  logic [2:0]  wr_rs_log [0:63];
  logic [23:0] conv_din_log [0:63];
  logic [1:0]  samp_ch_log [0:63];
  logic [23:0] samp_data_log [0:63];

  always @(negedge sys_clk) begin
    cyc       <= cyc + 1;
    prev_busy <= drv_busy;
    if (prev_busy && !drv_busy && kind == 2'd0) begin
      rst_done_cyc <= cyc;
      wr_after_rst <= 1'b1;
    end
    if ((drv_wrreq || drv_reset_req || drv_single_conv_req) && drv_busy) n_viol <= n_viol + 1;
    if (drv_reset_req) n_rst <= n_rst + 1;
    if (drv_wrreq) begin
      wr_din_log[n_wr % 64] <= drv_din;
      wr_rs_log[n_wr % 64]  <= drv_rs;
      n_wr <= n_wr + 1;
      if (wr_after_rst) begin
        last_gap     <= cyc - rst_done_cyc;
        wr_after_rst <= 1'b0;
      end
    end
    if (drv_single_conv_req) begin
      conv_din_log[n_conv % 64] <= drv_din;
      n_conv <= n_conv + 1;
    end
    if (sample_vld) begin
      samp_ch_log[n_samp % 64]   <= sample_ch;
      samp_data_log[n_samp % 64] <= sample_data;
      n_samp <= n_samp + 1;
    end
    if (scan_done) n_done <= n_done + 1;
  end

  int b_rst, b_wr, b_conv, b_samp, b_done;

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic snap();
    b_rst = n_rst; b_wr = n_wr; b_conv = n_conv; b_samp = n_samp; b_done = n_done;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    tick();
    stop = 1'b0;
  endtask

  task automatic wait_idle(input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      if (!running) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    repeat (2) tick();
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) tick();
    checks++; if (running !== 1'b0) begin failures++; $display("FAIL reset_running got=%b want=0", running); end
    checks++; if ({sample_vld, scan_done} !== 2'b00) begin failures++; $display("FAIL reset_strobes got=%b want=00", {sample_vld, scan_done}); end
    checks++; if ({drv_wrreq, drv_reset_req, drv_single_conv_req} !== 3'b000) begin failures++; $display("FAIL reset_reqs got=%b want=000", {drv_wrreq, drv_reset_req, drv_single_conv_req}); end
    checks++; if ({drv_rs, drv_din} !== 27'd0) begin failures++; $display("FAIL reset_drv_bus got=%h want=0", {drv_rs, drv_din}); end
    checks++; if ({sample_ch, sample_data} !== 26'd0) begin failures++; $display("FAIL reset_sample got=%h want=0", {sample_ch, sample_data}); end
    reset_n = 1'b1;
    repeat (2) tick();
  endtask

  task automatic test_single_pass();
    bit ok;
    snap();
    ch_mask = 3'b101; cont = 1'b0; cfg_base = 16'hABCD; rate = 4'h7;
    pulse_start();
    checks++; if (running !== 1'b1) begin failures++; $display("FAIL sp_running got=%b want=1", running); end
    wait_idle(2000, ok);
    checks++; if (ok !== 1'b1) begin failures++; $display("FAIL sp_timeout got=%b want=1", ok); end
    checks++; if (n_rst - b_rst !== 1) begin failures++; $display("FAIL sp_rst_count got=%0d want=1", n_rst - b_rst); end
    checks++; if (n_wr - b_wr !== 2) begin failures++; $display("FAIL sp_wr_count got=%0d want=2", n_wr - b_wr); end
    checks++; if (wr_rs_log[b_wr % 64] !== 3'd2) begin failures++; $display("FAIL sp_wr_rs got=%0d want=2", wr_rs_log[b_wr % 64]); end
    checks++; if (wr_din_log[b_wr % 64] !== 24'h00ABC8) begin failures++; $display("FAIL sp_wr_din0 got=%h want=00abc8", wr_din_log[b_wr % 64]); end
    checks++; if (wr_din_log[(b_wr + 1) % 64] !== 24'h00ABCA) begin failures++; $display("FAIL sp_wr_din1 got=%h want=00abca", wr_din_log[(b_wr + 1) % 64]); end
    checks++; if (conv_din_log[b_conv % 64] !== 24'h000007) begin failures++; $display("FAIL sp_conv_din got=%h want=000007", conv_din_log[b_conv % 64]); end
    checks++; if (n_samp - b_samp !== 2) begin failures++; $display("FAIL sp_samp_count got=%0d want=2", n_samp - b_samp); end
    checks++; if ({samp_ch_log[b_samp % 64], samp_data_log[b_samp % 64]} !== {2'd0, 24'hA5A5A5}) begin failures++; $display("FAIL sp_samp0 got=%0d/%h want=0/a5a5a5", samp_ch_log[b_samp % 64], samp_data_log[b_samp % 64]); end
    checks++; if ({samp_ch_log[(b_samp + 1) % 64], samp_data_log[(b_samp + 1) % 64]} !== {2'd2, 24'h123456}) begin failures++; $display("FAIL sp_samp1 got=%0d/%h want=2/123456", samp_ch_log[(b_samp + 1) % 64], samp_data_log[(b_samp + 1) % 64]); end
    checks++; if (n_done - b_done !== 1) begin failures++; $display("FAIL sp_done_count got=%0d want=1", n_done - b_done); end
    checks++; if (last_gap < int'(RstWait)) begin failures++; $display("FAIL sp_rst_gap got=%0d want>=%0d", last_gap, RstWait); end
    checks++; if (n_viol !== 0) begin failures++; $display("FAIL sp_busy_viol got=%0d want=0", n_viol); end
  endtask

  task automatic test_zero_mask();
    snap();
    ch_mask = 3'b000;
    pulse_start();
    checks++; if ({scan_done, running} !== 2'b10) begin failures++; $display("FAIL zm_done_now got=%b want=10", {scan_done, running}); end
    tick();
    checks++; if (scan_done !== 1'b0) begin failures++; $display("FAIL zm_done_once got=%b want=0", scan_done); end
    repeat (20) tick();
    checks++; if ((n_rst - b_rst) + (n_wr - b_wr) + (n_conv - b_conv) !== 0) begin failures++; $display("FAIL zm_no_reqs got=%0d want=0", (n_rst - b_rst) + (n_wr - b_wr) + (n_conv - b_conv)); end
  endtask

  task automatic test_cont_stop();
    bit ok;
    snap();
    dbl_ready = 1'b1;
    ch_mask = 3'b010; cont = 1'b1; cfg_base = 16'h0000; rate = 4'h2;
    pulse_start();
    for (int i = 0; i < 2000 && (n_conv - b_conv) < 4; i++) tick();
    checks++; if (n_conv - b_conv < 4) begin failures++; $display("FAIL cs_conv_timeout got=%0d want=4", n_conv - b_conv); end
    tick();
    pulse_stop();
    wait_idle(500, ok);
    checks++; if (ok !== 1'b1) begin failures++; $display("FAIL cs_timeout got=%b want=1", ok); end
    checks++; if (n_samp - b_samp !== 4) begin failures++; $display("FAIL cs_samp_count got=%0d want=4", n_samp - b_samp); end
    for (int k = 0; k < 4; k++) begin
      checks++; if ({samp_ch_log[(b_samp + k) % 64], samp_data_log[(b_samp + k) % 64]} !== {2'd1, 24'h654321}) begin failures++; $display("FAIL cs_samp%0d got=%0d/%h want=1/654321", k, samp_ch_log[(b_samp + k) % 64], samp_data_log[(b_samp + k) % 64]); end
    end
    checks++; if (n_done - b_done !== 3) begin failures++; $display("FAIL cs_done_count got=%0d want=3", n_done - b_done); end
    repeat (50) tick();
    checks++; if ({n_conv - b_conv, n_wr - b_wr, n_rst - b_rst} !== {32'd4, 32'd4, 32'd1}) begin failures++; $display("FAIL cs_req_counts got=%0d/%0d/%0d want=4/4/1", n_conv - b_conv, n_wr - b_wr, n_rst - b_rst); end
    checks++; if (n_viol !== 0) begin failures++; $display("FAIL cs_busy_viol got=%0d want=0", n_viol); end
    dbl_ready = 1'b0;
    cont = 1'b0;
  endtask

  task automatic test_start_ignored();
    bit ok;
    snap();
    ch_mask = 3'b011; cont = 1'b0; cfg_base = 16'h0008; rate = 4'h1;
    pulse_start();
    for (int i = 0; i < 2000 && (n_wr - b_wr) < 1; i++) tick();
    ch_mask = 3'b100;
    pulse_start();
    wait_idle(2000, ok);
    checks++; if (ok !== 1'b1) begin failures++; $display("FAIL si_timeout got=%b want=1", ok); end
    checks++; if ({n_rst - b_rst, n_samp - b_samp, n_done - b_done} !== {32'd1, 32'd2, 32'd1}) begin failures++; $display("FAIL si_counts got=%0d/%0d/%0d want=1/2/1", n_rst - b_rst, n_samp - b_samp, n_done - b_done); end
    checks++; if ({samp_ch_log[b_samp % 64], samp_ch_log[(b_samp + 1) % 64]} !== 4'b0001) begin failures++; $display("FAIL si_channels got=%0d,%0d want=0,1", samp_ch_log[b_samp % 64], samp_ch_log[(b_samp + 1) % 64]); end
    checks++; if (wr_din_log[(b_wr + 1) % 64] !== 24'h000009) begin failures++; $display("FAIL si_wr_din1 got=%h want=000009", wr_din_log[(b_wr + 1) % 64]); end
  endtask

  task automatic test_stop_rwait();
    bit ok;
    snap();
    ch_mask = 3'b111; cont = 1'b0;
    pulse_start();
    for (int i = 0; i < 100 && (n_rst - b_rst) < 1; i++) tick();
    repeat (15) tick();
    pulse_stop();
    wait_idle(200, ok);
    checks++; if (ok !== 1'b1) begin failures++; $display("FAIL sr_timeout got=%b want=1", ok); end
    repeat (30) tick();
    checks++; if ({n_rst - b_rst, n_wr - b_wr, n_conv - b_conv} !== {32'd1, 32'd0, 32'd0}) begin failures++; $display("FAIL sr_req_counts got=%0d/%0d/%0d want=1/0/0", n_rst - b_rst, n_wr - b_wr, n_conv - b_conv); end
    checks++; if ({n_samp - b_samp, n_done - b_done} !== {32'd0, 32'd0}) begin failures++; $display("FAIL sr_outputs got=%0d/%0d want=0/0", n_samp - b_samp, n_done - b_done); end
  endtask

  task automatic test_async_reset();
    bit ok;
    snap();
    ch_mask = 3'b001; cont = 1'b0; rate = 4'h9;
    pulse_start();
    for (int i = 0; i < 2000 && (n_conv - b_conv) < 1; i++) tick();
    repeat (3) tick();
    checks++; if ({running, drv_busy} !== 2'b11) begin failures++; $display("FAIL ar_pre got=%b want=11", {running, drv_busy}); end
    #2 reset_n = 1'b0;
    #1;
    checks++; if ({running, sample_vld, scan_done, drv_wrreq, drv_reset_req, drv_single_conv_req} !== 6'd0) begin failures++; $display("FAIL ar_ctrl got=%b want=000000", {running, sample_vld, scan_done, drv_wrreq, drv_reset_req, drv_single_conv_req}); end
    checks++; if ({drv_rs, drv_din} !== 27'd0) begin failures++; $display("FAIL ar_bus got=%h want=0", {drv_rs, drv_din}); end
    tick();
    reset_n = 1'b1;
    repeat (3) tick();
    snap();
    ch_mask = 3'b110; cfg_base = 16'h0010; rate = 4'h3;
    pulse_start();
    wait_idle(2000, ok);
    checks++; if (ok !== 1'b1) begin failures++; $display("FAIL ar_timeout got=%b want=1", ok); end
    checks++; if ({n_rst - b_rst, n_samp - b_samp, n_done - b_done} !== {32'd1, 32'd2, 32'd1}) begin failures++; $display("FAIL ar_counts got=%0d/%0d/%0d want=1/2/1", n_rst - b_rst, n_samp - b_samp, n_done - b_done); end
    checks++; if ({wr_din_log[b_wr % 64], wr_din_log[(b_wr + 1) % 64]} !== {24'h000011, 24'h000012}) begin failures++; $display("FAIL ar_wr_din got=%h,%h want=000011,000012", wr_din_log[b_wr % 64], wr_din_log[(b_wr + 1) % 64]); end
    checks++; if ({samp_ch_log[b_samp % 64], samp_data_log[b_samp % 64], samp_ch_log[(b_samp + 1) % 64], samp_data_log[(b_samp + 1) % 64]} !== {2'd1, 24'h654321, 2'd2, 24'h123456}) begin failures++; $display("FAIL ar_samples got=%0d/%h,%0d/%h want=1/654321,2/123456", samp_ch_log[b_samp % 64], samp_data_log[b_samp % 64], samp_ch_log[(b_samp + 1) % 64], samp_data_log[(b_samp + 1) % 64]); end
    checks++; if (n_viol !== 0) begin failures++; $display("FAIL ar_busy_viol got=%0d want=0", n_viol); end
  endtask

  initial begin
    test_reset();
    test_single_pass();
    test_zero_mask();
    test_cont_stop();
    test_start_ignored();
    test_stop_rwait();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ad7799_scan.md
Name: ad7799_scan

Overview:
- Channel-scan sequencer for the ad7799 SPI driver. Resets the ADC once per start, then round-robins over the enabled input channels.
- For each channel it writes the configuration register, runs a single conversion and returns the 24-bit result as a one-cycle sample strobe.
- It sits between the host/register file and the ad7799 driver, and is the only master of the driver's request inputs.

Parameters:
- RST_WAIT, 5000, idle cycles after the ADC reset command before first access (≥500 µs at sys_clk).
- CNT_W, 16, width of the wait counter; must hold RST_WAIT.

Ports:
- sys_clk  in  1  single clock; the driver's phy_clk is driven from the same clock.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; begin a scan.
- stop  in  1  one-cycle pulse; end the scan after the current channel.
- cont  in  1  sampled at start; 1 = loop passes forever, 0 = single pass.
- ch_mask  in  3  enabled channels, bit n = AIN(n+1); sampled at start.
- cfg_base  in  16  configuration register template; bits [2:0] are replaced by the channel.
- rate  in  4  update-rate code passed to the driver's din[3:0] for conversions.
- drv_wrreq  out  1  to driver wrreq.
- drv_reset_req  out  1  to driver reset_req.
- drv_single_conv_req  out  1  to driver single_conv_req.
- drv_rs  out  3  to driver rs.
- drv_din  out  24  to driver din.
- drv_busy  in  1  from driver busy.
- drv_ready  in  1  from driver ready.
- drv_dout  in  24  from driver dout.
- running  out  1  high from start acceptance until return to IDLE.
- sample_vld  out  1  one-cycle strobe carrying a new result.
- sample_ch  out  2  channel index 0..2 of sample_data.
- sample_data  out  24  conversion result.
- scan_done  out  1  one-cycle strobe at the end of each full pass.

Behaviour:
- Reset state: all outputs 0, state IDLE, channel pointer 0, wait counter 0.
- Driver handshake:
  - Every request is a one-cycle pulse, issued only in a cycle where drv_busy = 0.
  - After a pulse the FSM waits for drv_busy = 1 (ACK), then for drv_busy = 0 (DONE).
  - No second request is issued before DONE.
  - drv_rs and drv_din are valid in the pulse cycle and held until ACK.
- IDLE:
  - start with ch_mask ≠ 0 latches cont/ch_mask, sets running, goes to RST.
  - start with ch_mask = 0: scan_done pulses next cycle, running stays 0.
- RST: pulse drv_reset_req, then ACK and DONE, then load the counter with RST_WAIT and go to RWAIT.
- RWAIT:
  - Decrement the counter.
  - At 0, point the channel pointer at the lowest set mask bit and go to CFG.
- CFG:
  - Pulse drv_wrreq with drv_rs = 3'd2 and drv_din = {8'h00, cfg_base[15:3], ch[2:0]}, where ch = pointer (0 → AIN1 = 3'b000).
  - Then ACK, DONE, go to CONV.
- CONV:
  - Pulse drv_single_conv_req with drv_din = {20'h0, rate}.
  - Wait for ACK.
  - Capture drv_dout on the cycle after drv_ready = 1, because the driver updates dout in the same edge as ready.
  - On capture, pulse sample_vld with sample_ch = pointer.
  - Wait for DONE, then go to NEXT.
- NEXT:
  - If a stop is pending, go to IDLE, clear running, and do not pulse scan_done.
  - Otherwise advance the pointer to the next set mask bit above the current one, wrapping.
  - On wrap, or when only one channel is enabled, pulse scan_done. Then:
    - cont = 0: go to IDLE.
    - cont = 1: go to CFG.
- stop:
  - Latched as pending in any non-IDLE state and cleared on entry to IDLE.
  - Never aborts an in-flight driver transaction.
  - stop during RST or RWAIT: finish the reset transaction, then go to IDLE without converting.
- start while running is ignored. start and stop in the same IDLE cycle: start wins; stop is ignored.
- drv_ready outside CONV is ignored. A second drv_ready within one CONV produces no second sample.
- ch_mask, cfg_base, rate and cont changes mid-scan:
  - ch_mask and cont take effect at the next start only.
  - cfg_base and rate are sampled at each request issue.
- reset_n assertion mid-operation returns to reset state immediately. The driver must be reset by the same signal.

Test Plan:
- start, ch_mask=3'b101, cont=0, RST_WAIT=20, model driver with 8-cycle busy and ready data 24'hA5A5A5 (ch0) / 24'h123456 (ch2) → one reset_req; wrreq rs=2 din[2:0]=0; sample(ch0, A5A5A5); wrreq din[2:0]=2; sample(ch2, 123456); one scan_done; running drops.
- Assert no request pulse ever occurs while drv_busy=1, and ≥RST_WAIT cycles elapse between reset DONE and the first wrreq.
- cont=1, mask=3'b010 → repeated ch1 samples, scan_done after every sample. stop mid-CONV → that sample still emitted, then IDLE, no further requests.
- start with mask=0 → scan_done one cycle later, no driver requests.
- start pulsed while running → no effect on sequence. stop during RWAIT → reset completes, IDLE, no wrreq.
- reset_n low during CONV_WAIT → all outputs 0 asynchronously. After release, a new start runs a full correct pass.
